// File: rtl/serial_full_subtractor.sv
// -----------------------------------------------------------------------------
// serial_full_subtractor
//
// Bit-serial, LSB-first word subtractor: DIFF = A - B - Borrow_in over
// WIDTH-bit words. Each accepted bit takes one borrow from the previous bit of
// the same word; the first bit of a word takes Borrow_in as its seed. The
// datapath has two register stages, so out_valid appears exactly 2 cycles
// after the input bit is accepted. It accepts one bit per cycle and has no
// backpressure.
//
// Optional feature macro: SUB_SIGNED_OVF_EN
//   When defined, output ovf flags two's-complement overflow of the word on its
//   out_last beat. When undefined, the port and its logic are absent.
//
// Parameters
//   WIDTH       bits per word (2..64)
//
// Ports
//   clk         in   clock, all state updates on posedge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   A/B/in_first/Borrow_in valid this cycle
//   in_first    in   marks bit 0 of a word
//   A           in   minuend bit
//   B           in   subtrahend bit
//   Borrow_in   in   word borrow seed, sampled only with in_valid & in_first
//   Diff        out  difference bit
//   Borrow_out  out  borrow out of this bit (word borrow when out_last)
//   out_valid   out  Diff/Borrow_out valid
//   out_last    out  marks bit WIDTH-1 of a word
//   frame_err   out  1-cycle framing violation pulse, aligned with out_valid
//   ovf         out  signed overflow on the out_last beat (macro builds only)
// -----------------------------------------------------------------------------
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_first,
  input  logic A,
  input  logic B,
  input  logic Borrow_in,
  output logic Diff,
  output logic Borrow_out,
  output logic out_valid,
  output logic out_last,
  output logic frame_err
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          borrow_q, borrow_d;

  // Per-bit combinational results.
  logic          accept;    // bit enters the pipeline
  logic          is_last;   // bit is WIDTH-1 of the current word
  logic          is_err;    // framing violation seen on this input
  logic          bsel;      // borrow into this bit
  logic          d_bit;
  logic          bo_bit;

  // Stage 1 registers.
  logic          valid_s1_q, d_s1_q, bo_s1_q, last_s1_q, err_s1_q;

  // Stage 2 (output) registers.
  logic          valid_s2_q, d_s2_q, bo_s2_q, last_s2_q, err_s2_q;

`ifdef SUB_SIGNED_OVF_EN
  logic          ovf_s1_q, ovf_s2_q;
`endif

  // ---------------------------------------------------------------------------
  // Framing FSM and bit arithmetic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    borrow_d  = borrow_q;
    accept    = 1'b0;
    is_last   = 1'b0;
    is_err    = 1'b0;
    bsel      = borrow_q;

    if (in_valid) begin
      if (in_first) begin
        // Start of a word. In RUN this aborts the word in flight: the new bit
        // is still emitted, but flagged, and the old word never sees out_last.
        accept    = 1'b1;
        bsel      = Borrow_in;
        is_err    = (state_q == RUN);
        state_d   = RUN;
        bit_cnt_d = CW'(1);
      end else if (state_q == RUN) begin
        accept = 1'b1;
        if (bit_cnt_q == CW'(WIDTH - 1)) begin
          is_last   = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end else begin
        // Mid-word bit with no word open: dropped, but reported.
        is_err = 1'b1;
      end
    end

    d_bit  = A ^ B ^ bsel;
    bo_bit = (~A & B) | (~(A ^ B) & bsel);

    if (accept) begin
      borrow_d = bo_bit;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      borrow_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      borrow_q  <= borrow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-stage output pipeline. Data is zeroed on bubbles so the outputs read
  // 0 whenever out_valid is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1_q <= 1'b0;
      d_s1_q     <= 1'b0;
      bo_s1_q    <= 1'b0;
      last_s1_q  <= 1'b0;
      err_s1_q   <= 1'b0;
      valid_s2_q <= 1'b0;
      d_s2_q     <= 1'b0;
      bo_s2_q    <= 1'b0;
      last_s2_q  <= 1'b0;
      err_s2_q   <= 1'b0;
    end else begin
      valid_s1_q <= accept;
      d_s1_q     <= accept & d_bit;
      bo_s1_q    <= accept & bo_bit;
      last_s1_q  <= is_last;
      err_s1_q   <= is_err;
      valid_s2_q <= valid_s1_q;
      d_s2_q     <= d_s1_q;
      bo_s2_q    <= bo_s1_q;
      last_s2_q  <= last_s1_q;
      err_s2_q   <= err_s1_q;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  // On the MSB, overflow is the borrow into the bit XOR the borrow out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_s1_q <= 1'b0;
      ovf_s2_q <= 1'b0;
    end else begin
      ovf_s1_q <= is_last & (bsel ^ bo_bit);
      ovf_s2_q <= ovf_s1_q;
    end
  end

  assign ovf = ovf_s2_q;
`endif

  assign Diff       = d_s2_q;
  assign Borrow_out = bo_s2_q;
  assign out_valid  = valid_s2_q;
  assign out_last   = last_s2_q;
  assign frame_err  = err_s2_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_full_subtractor
//
// Directed bench for serial_full_subtractor with WIDTH=8. Words are driven
// LSB first on the falling edge; a monitor collects every out_valid beat on the
// falling edge together with its cycle number, so each task can check the
// result word, the out_last/frame_err placement and the 2-cycle latency.
// -----------------------------------------------------------------------------
module tb_serial_full_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  logic in_valid, in_first, A, B, Borrow_in;
  logic Diff, Borrow_out, out_valid, out_last, frame_err;
`ifdef SUB_SIGNED_OVF_EN
  logic ovf;
`endif

  serial_full_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_first   (in_first),
    .A          (A),
    .B          (B),
    .Borrow_in  (Borrow_in),
    .Diff       (Diff),
    .Borrow_out (Borrow_out),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .frame_err  (frame_err)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic d;
    logic bo;
    logic last;
    logic err;
    logic ovf;
    int   cyc;
  } beat_t;

  int    cyc      = 0;
  int    drop_cnt = 0;
  int    checks   = 0;
  int    errors   = 0;
  beat_t out_q[$];
  int    acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      beat_t b;
      b.d    = Diff;
      b.bo   = Borrow_out;
      b.last = out_last;
      b.err  = frame_err;
`ifdef SUB_SIGNED_OVF_EN
      b.ovf  = ovf;
`else
      b.ovf  = 1'b0;
`endif
      b.cyc  = cyc;
      out_q.push_back(b);
    end
    if (rst_n && frame_err && !out_valid) drop_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic f, input logic a,
                       input logic b, input logic bin);
    @(negedge clk);
    in_valid  = v;
    in_first  = f;
    A         = a;
    B         = b;
    Borrow_in = bin;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends the first n bits of a word; a set bit in holes puts a bubble before
  // that bit. Borrow_in is inverted on non-first bits to prove it is ignored.
  task automatic send_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic bin, input logic [WIDTH-1:0] holes,
                           input int n);
    for (int i = 0; i < n; i++) begin
      if (holes[i]) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, (i == 0), a[i], b[i], (i == 0) ? bin : ~bin);
      acc_q.push_back(cyc);
    end
  endtask

  // Pops one complete word from the monitor and compares it.
  task automatic check_word(input string name, input logic [WIDTH-1:0] exp_diff,
                            input logic exp_bo, input logic exp_ovf,
                            input logic exp_err0);
    logic [WIDTH-1:0] diff_v, last_v, err_v, exp_err_v;
    logic             bo_last, ovf_last;
    int               late;
    beat_t            bt;
    int               ac;
    checks++;
    if (out_q.size() < WIDTH || acc_q.size() < WIDTH) begin
      errors++;
      $display("FAIL %s beats: got %0d beats, required %0d", name, out_q.size(), WIDTH);
      out_q.delete();
      acc_q.delete();
      return;
    end
    late = 0;
    for (int i = 0; i < WIDTH; i++) begin
      bt = out_q.pop_front();
      ac = acc_q.pop_front();
      diff_v[i] = bt.d;
      last_v[i] = bt.last;
      err_v[i]  = bt.err;
      if (bt.cyc != ac + 2) late++;
      if (i == WIDTH - 1) begin
        bo_last  = bt.bo;
        ovf_last = bt.ovf;
      end
    end
    exp_err_v = '0;
    exp_err_v[0] = exp_err0;
    if (late !== 0) begin
      errors++;
      $display("FAIL %s latency: %0d beats not 2 cycles after accept, required 0", name, late);
    end
    checks++;
    if (diff_v !== exp_diff) begin
      errors++;
      $display("FAIL %s diff: got %h, required %h", name, diff_v, exp_diff);
    end
    checks++;
    if (bo_last !== exp_bo) begin
      errors++;
      $display("FAIL %s borrow_out: got %b, required %b", name, bo_last, exp_bo);
    end
    checks++;
    if (last_v !== 8'h80) begin
      errors++;
      $display("FAIL %s out_last: got %b, required 10000000", name, last_v);
    end
    checks++;
    if (err_v !== exp_err_v) begin
      errors++;
      $display("FAIL %s frame_err: got %b, required %b", name, err_v, exp_err_v);
    end
`ifdef SUB_SIGNED_OVF_EN
    checks++;
    if (ovf_last !== exp_ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b, required %b", name, ovf_last, exp_ovf);
    end
`else
    if (ovf_last !== 1'b0 && exp_ovf === 1'b1) begin
      // ovf is not built; nothing to compare.
    end
`endif
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({Diff, Borrow_out, out_valid, out_last, frame_err} !== 5'b0) begin
      errors++;
      $display("FAIL %s: outputs got %b, required 00000", name,
               {Diff, Borrow_out, out_valid, out_last, frame_err});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; A = 1'b0; B = 1'b0; Borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    send_word(8'h05, 8'h03, 1'b0, 8'h00, WIDTH);
    idle(4);
    check_word("basic_05_03", 8'h02, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_word(8'h00, 8'h01, 1'b0, 8'h00, WIDTH);
    send_word(8'h10, 8'h10, 1'b1, 8'h00, WIDTH);
    idle(4);
    check_word("b2b_00_01", 8'hFF, 1'b1, 1'b0, 1'b0);
    check_word("b2b_10_10_bin", 8'hFF, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bubbles();
    // Bubbles before bits 2 and 5.
    send_word(8'h3C, 8'h0F, 1'b0, 8'b0010_0100, WIDTH);
    idle(4);
    check_word("bubbles_3C_0F", 8'h2D, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_frame_err();
    logic [3:0] part_d, part_last, part_err;
    beat_t      bt;
    int         drops_before;
    // Four bits of a word, then a new word starts at what would be bit 4.
    send_word(8'hFF, 8'h00, 1'b0, 8'h00, 4);
    send_word(8'h20, 8'h31, 1'b0, 8'h00, WIDTH);
    idle(4);
    checks++;
    if (out_q.size() != 4 + WIDTH) begin
      errors++;
      $display("FAIL abort_beats: got %0d beats, required %0d", out_q.size(), 4 + WIDTH);
      out_q.delete();
      acc_q.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        bt = out_q.pop_front();
        void'(acc_q.pop_front());
        part_d[i]    = bt.d;
        part_last[i] = bt.last;
        part_err[i]  = bt.err;
      end
      checks++;
      if ({part_d, part_last, part_err} !== {4'hF, 4'h0, 4'h0}) begin
        errors++;
        $display("FAIL aborted_word: got d=%b last=%b err=%b, required d=1111 last=0000 err=0000",
                 part_d, part_last, part_err);
      end
      check_word("restart_20_31", 8'hEF, 1'b1, 1'b0, 1'b1);
    end
    // Bit without in_first while idle: dropped with a bare frame_err pulse.
    drops_before = drop_cnt;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (out_q.size() !== 0 || drop_cnt !== drops_before + 1) begin
      errors++;
      $display("FAIL idle_drop: got beats=%0d err_pulses=%0d, required beats=0 err_pulses=1",
               out_q.size(), drop_cnt - drops_before);
    end
    out_q.delete();
    // The block must still be framed correctly after the drop.
    send_word(8'h05, 8'h03, 1'b0, 8'h00, WIDTH);
    idle(4);
    check_word("after_drop", 8'h02, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_word();
    send_word(8'hF0, 8'h0F, 1'b0, 8'h00, 4);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got %b, required 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    idle(2);
    out_q.delete();
    acc_q.delete();
    rst_n = 1'b1;
    idle(2);
    send_word(8'hAA, 8'h55, 1'b0, 8'h00, WIDTH);
    idle(4);
    check_word("post_reset_AA_55", 8'h55, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef SUB_SIGNED_OVF_EN
  task automatic test_ovf();
    send_word(8'h80, 8'h01, 1'b0, 8'h00, WIDTH);
    send_word(8'h7F, 8'hFF, 1'b0, 8'h00, WIDTH);
    send_word(8'h05, 8'h03, 1'b0, 8'h00, WIDTH);
    idle(4);
    check_word("ovf_80_01", 8'h7F, 1'b0, 1'b1, 1'b0);
    check_word("ovf_7F_FF", 8'h80, 1'b1, 1'b1, 1'b0);
    check_word("ovf_05_03", 8'h02, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bubbles();
    test_frame_err();
    test_reset_mid_word();
`ifdef SUB_SIGNED_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
